// File: rtl/aurora_tx_arbiter.sv
// rtl/aurora_tx_arbiter.sv - frame-atomic 2:1 arbiter sharing the Aurora 64-bit TX stream
module aurora_tx_arbiter #(
  parameter int STAT_BURST_MAX = 4,
  parameter int CNT_W          = 16
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             ENABLE,
  input  logic [63:0]      DATA_TDATA,
  input  logic             DATA_TLAST,
  input  logic             DATA_TVALID,
  output logic             DATA_TREADY,
  input  logic [63:0]      STAT_TDATA,
  input  logic             STAT_TLAST,
  input  logic             STAT_TVALID,
  output logic             STAT_TREADY,
  output logic [63:0]      S_AXI_TX_TDATA,
  output logic             S_AXI_TX_TLAST,
  output logic             S_AXI_TX_TVALID,
  input  logic             S_AXI_TX_TREADY,
  output logic             BUSY,
  output logic [CNT_W-1:0] DATA_FRAME_CNT,
  output logic [CNT_W-1:0] STAT_FRAME_CNT
);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_DATA = 2'd1, ST_STAT = 2'd2} state_t;

  localparam logic [3:0] RUN_LIMIT = 4'(STAT_BURST_MAX);
  localparam logic [3:0] RUN_SAT   = 4'd15;

  state_t             state_q, state_d;
  logic [63:0]        tdata_q, tdata_d;
  logic               tlast_q, tlast_d;
  logic               tvalid_q, tvalid_d;
  logic [3:0]         run_q, run_d;
  logic [CNT_W-1:0]   data_cnt_q, data_cnt_d;
  logic [CNT_W-1:0]   stat_cnt_q, stat_cnt_d;

  logic load_ok;
  logic data_xfer;
  logic stat_xfer;

  // The output register can take a new word when empty or draining this cycle
  assign load_ok     = !tvalid_q || S_AXI_TX_TREADY;
  assign DATA_TREADY = load_ok && (state_q == ST_DATA);
  assign STAT_TREADY = load_ok && (state_q == ST_STAT);
  assign data_xfer   = DATA_TVALID && DATA_TREADY;
  assign stat_xfer   = STAT_TVALID && STAT_TREADY;

  assign S_AXI_TX_TDATA  = tdata_q;
  assign S_AXI_TX_TLAST  = tlast_q;
  assign S_AXI_TX_TVALID = tvalid_q;
  assign BUSY            = (state_q != ST_IDLE) || tvalid_q;
  assign DATA_FRAME_CNT  = data_cnt_q;
  assign STAT_FRAME_CNT  = stat_cnt_q;

  // Next-state: output register load/drain, grant decision in IDLE, frame-end bookkeeping
  always_comb begin
    state_d    = state_q;
    tdata_d    = tdata_q;
    tlast_d    = tlast_q;
    tvalid_d   = tvalid_q;
    run_d      = run_q;
    data_cnt_d = data_cnt_q;
    stat_cnt_d = stat_cnt_q;

    if (tvalid_q && S_AXI_TX_TREADY) begin
      tvalid_d = 1'b0;
    end
    if (data_xfer) begin
      tdata_d  = DATA_TDATA;
      tlast_d  = DATA_TLAST;
      tvalid_d = 1'b1;
    end else if (stat_xfer) begin
      tdata_d  = STAT_TDATA;
      tlast_d  = STAT_TLAST;
      tvalid_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        // Status wins unless it has already used its burst while data waits
        if (ENABLE) begin
          if (STAT_TVALID && (!DATA_TVALID || (run_q < RUN_LIMIT))) begin
            state_d = ST_STAT;
          end else if (DATA_TVALID) begin
            state_d = ST_DATA;
            run_d   = 4'd0;
          end
        end
      end
      ST_DATA: begin
        if (data_xfer && DATA_TLAST) begin
          state_d    = ST_IDLE;
          data_cnt_d = data_cnt_q + CNT_W'(1);
          run_d      = 4'd0;
        end
      end
      ST_STAT: begin
        if (stat_xfer && STAT_TLAST) begin
          state_d    = ST_IDLE;
          stat_cnt_d = stat_cnt_q + CNT_W'(1);
          run_d      = (run_q == RUN_SAT) ? RUN_SAT : run_q + 4'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any frame in flight
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q    <= ST_IDLE;
      tdata_q    <= '0;
      tlast_q    <= 1'b0;
      tvalid_q   <= 1'b0;
      run_q      <= 4'd0;
      data_cnt_q <= '0;
      stat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      tdata_q    <= tdata_d;
      tlast_q    <= tlast_d;
      tvalid_q   <= tvalid_d;
      run_q      <= run_d;
      data_cnt_q <= data_cnt_d;
      stat_cnt_q <= stat_cnt_d;
    end
  end

endmodule

// File: tb/tb_aurora_tx_arbiter.sv
// tb/tb_aurora_tx_arbiter.sv - self-checking bench for aurora_tx_arbiter
module tb_aurora_tx_arbiter;

  localparam int BURST = 4;
  localparam int CW    = 4;

  logic          CLK = 1'b0;
  logic          RESET_N = 1'b1;
  logic          ENABLE = 1'b1;
  logic [63:0]   DATA_TDATA = '0;
  logic          DATA_TLAST = 1'b0;
  logic          DATA_TVALID = 1'b0;
  logic          DATA_TREADY;
  logic [63:0]   STAT_TDATA = '0;
  logic          STAT_TLAST = 1'b0;
  logic          STAT_TVALID = 1'b0;
  logic          STAT_TREADY;
  logic [63:0]   S_AXI_TX_TDATA;
  logic          S_AXI_TX_TLAST;
  logic          S_AXI_TX_TVALID;
  logic          S_AXI_TX_TREADY = 1'b0;
  logic          BUSY;
  logic [CW-1:0] DATA_FRAME_CNT;
  logic [CW-1:0] STAT_FRAME_CNT;

  aurora_tx_arbiter #(.STAT_BURST_MAX(BURST), .CNT_W(CW)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .ENABLE(ENABLE),
    .DATA_TDATA(DATA_TDATA), .DATA_TLAST(DATA_TLAST), .DATA_TVALID(DATA_TVALID), .DATA_TREADY(DATA_TREADY),
    .STAT_TDATA(STAT_TDATA), .STAT_TLAST(STAT_TLAST), .STAT_TVALID(STAT_TVALID), .STAT_TREADY(STAT_TREADY),
    .S_AXI_TX_TDATA(S_AXI_TX_TDATA), .S_AXI_TX_TLAST(S_AXI_TX_TLAST),
    .S_AXI_TX_TVALID(S_AXI_TX_TVALID), .S_AXI_TX_TREADY(S_AXI_TX_TREADY),
    .BUSY(BUSY), .DATA_FRAME_CNT(DATA_FRAME_CNT), .STAT_FRAME_CNT(STAT_FRAME_CNT)
  );

  initial forever #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;

  // Words are {last, is_data, tag[30:0], index[31:0]}
  logic [64:0] dq[$];
  logic [64:0] sq[$];
  logic [64:0] exp_q[$];

  bit          d_xfer, s_xfer;
  int          d_gap, s_gap, d_sent, gap_max, trdy_mode, pat_i, cyc;
  int          n_out, first_cyc, last_cyc;
  logic [31:0] order;

  task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic flush();
    dq.delete(); sq.delete(); exp_q.delete();
    d_xfer = 0; s_xfer = 0; d_gap = 0; s_gap = 0; d_sent = 0;
    gap_max = 0; trdy_mode = 0; n_out = 0; order = '0;
  endtask

  task automatic do_reset(input int n);
    RESET_N = 1'b0;
    flush();
    #1;
    check("reset_outputs", {3'b0, S_AXI_TX_TDATA, S_AXI_TX_TLAST, S_AXI_TX_TVALID, DATA_TREADY,
                            STAT_TREADY, BUSY, DATA_FRAME_CNT, STAT_FRAME_CNT}, '0);
    repeat (n) @(posedge CLK);
    #2;
    RESET_N = 1'b1;
  endtask

  task automatic add_frame(input bit is_data, input int len, input logic [30:0] tag);
    for (int i = 0; i < len; i++) begin
      if (is_data) dq.push_back({(i == len - 1), 1'b1, tag, 32'(i)});
      else         sq.push_back({(i == len - 1), 1'b0, tag, 32'(i)});
    end
  endtask

  // Reference arbitration over whole frames, assuming both queues were loaded right after reset
  task automatic plan();
    logic [64:0] md[$];
    logic [64:0] ms[$];
    logic [64:0] w;
    int          run;
    bit          take_stat;
    md = dq; ms = sq; run = 0;
    while (md.size() != 0 || ms.size() != 0) begin
      take_stat = (ms.size() != 0) && ((md.size() == 0) || (run < BURST));
      if (take_stat) run = (run >= 15) ? 15 : run + 1;
      else           run = 0;
      do begin
        w = take_stat ? ms.pop_front() : md.pop_front();
        exp_q.push_back(w);
      end while (!w[64]);
    end
  endtask

  task automatic wait_sent(input int n);
    for (int i = 0; i < 300 && d_sent < n; i++) begin
      @(posedge CLK); #2;
    end
    check("wait_data_words", 80'(d_sent >= n), 80'(1));
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) @(posedge CLK);
    repeat (2) @(posedge CLK);
    #2;
    check("drain_remaining", 80'(exp_q.size()), 80'(0));
  endtask

  // Source and sink driver: advance queues after accepted words, present the next one
  initial begin
    logic [64:0] tmp;
    forever begin
      @(posedge CLK); #1;
      cyc++;
      if (d_xfer) begin
        d_xfer = 0; d_sent++;
        tmp = dq.pop_front();
        if (!tmp[64] && gap_max > 0) d_gap = $urandom_range(gap_max, 0);
      end
      if (s_xfer) begin
        s_xfer = 0;
        tmp = sq.pop_front();
        if (!tmp[64] && gap_max > 0) s_gap = $urandom_range(gap_max, 0);
      end
      if (d_gap > 0) begin DATA_TVALID = 1'b0; d_gap--; end
      else DATA_TVALID = (dq.size() != 0);
      if (s_gap > 0) begin STAT_TVALID = 1'b0; s_gap--; end
      else STAT_TVALID = (sq.size() != 0);
      if (dq.size() != 0) {DATA_TLAST, DATA_TDATA} = dq[0];
      else {DATA_TLAST, DATA_TDATA} = '0;
      if (sq.size() != 0) {STAT_TLAST, STAT_TDATA} = sq[0];
      else {STAT_TLAST, STAT_TDATA} = '0;
      case (trdy_mode)
        1:       begin S_AXI_TX_TREADY = (pat_i % 4 == 0) || (pat_i % 4 == 3); pat_i++; end
        2:       S_AXI_TX_TREADY = ($urandom_range(3, 0) != 0);
        default: S_AXI_TX_TREADY = 1'b1;
      endcase
    end
  end

  // Monitor on the falling edge: record accepted source words, score output words
  initial begin
    logic [64:0] w;
    forever begin
      @(negedge CLK);
      if (RESET_N) begin
        if (DATA_TVALID && DATA_TREADY) d_xfer = 1;
        if (STAT_TVALID && STAT_TREADY) s_xfer = 1;
        if (S_AXI_TX_TVALID && !S_AXI_TX_TREADY)
          check("ready_while_held", {78'b0, DATA_TREADY, STAT_TREADY}, '0);
        if (S_AXI_TX_TVALID && S_AXI_TX_TREADY) begin
          if (exp_q.size() == 0) begin
            check("unexpected_word", {79'b0, S_AXI_TX_TVALID}, '0);
          end else begin
            w = exp_q.pop_front();
            check("out_word", {15'b0, S_AXI_TX_TLAST, S_AXI_TX_TDATA}, {15'b0, w});
          end
          if (n_out == 0) first_cyc = cyc;
          last_cyc = cyc;
          n_out++;
          if (S_AXI_TX_TLAST) order = {order[30:0], S_AXI_TX_TDATA[63]};
        end
      end
    end
  end

  initial begin
    int nd, ns;
    #2;

    // Single 9-word data frame after reset
    do_reset(3);
    add_frame(1'b1, 9, 31'd0);
    plan();
    wait_drain(200);
    check("single_words", 80'(n_out), 80'(9));
    check("single_contiguous", 80'(last_cyc - first_cyc), 80'(8));
    check("single_data_cnt", 80'(DATA_FRAME_CNT), 80'(1));
    check("single_busy", 80'(BUSY), 80'(0));

    // Status priority limited by the burst counter
    do_reset(2);
    for (int i = 0; i < 8; i++) add_frame(1'b0, 2, 31'(100 + i));
    add_frame(1'b1, 9, 31'd1);
    add_frame(1'b1, 9, 31'd2);
    plan();
    wait_drain(500);
    check("grant_order", 80'(order[9:0]), 80'(10'b0000100001));
    check("prio_stat_cnt", 80'(STAT_FRAME_CNT), 80'(8));
    check("prio_data_cnt", 80'(DATA_FRAME_CNT), 80'(2));

    // Back-pressure pattern 1,0,0,1
    do_reset(2);
    trdy_mode = 1; pat_i = 0;
    add_frame(1'b1, 9, 31'd3);
    plan();
    wait_drain(300);
    check("bp_words", 80'(n_out), 80'(9));
    check("bp_data_cnt", 80'(DATA_FRAME_CNT), 80'(1));

    // Frame atomicity with status arriving and ENABLE dropping mid-frame
    do_reset(2);
    add_frame(1'b1, 9, 31'd4);
    plan();
    wait_sent(3);
    add_frame(1'b0, 2, 31'd5);
    foreach (sq[i]) exp_q.push_back(sq[i]);
    wait_sent(5);
    ENABLE = 1'b0;
    wait_sent(9);
    repeat (3) @(posedge CLK);
    #2;
    for (int i = 0; i < 4; i++) begin
      check("disabled_stat_ready", 80'(STAT_TREADY), 80'(0));
      check("disabled_busy", 80'(BUSY), 80'(0));
      @(posedge CLK); #2;
    end
    check("disabled_data_cnt", 80'(DATA_FRAME_CNT), 80'(1));
    check("disabled_stat_cnt", 80'(STAT_FRAME_CNT), 80'(0));
    check("disabled_pending", 80'(exp_q.size()), 80'(2));
    ENABLE = 1'b1;
    wait_drain(200);
    check("reenabled_stat_cnt", 80'(STAT_FRAME_CNT), 80'(1));

    // Asynchronous reset in the middle of a data frame
    do_reset(2);
    add_frame(1'b0, 1, 31'd6);
    add_frame(1'b1, 9, 31'd7);
    plan();
    wait_sent(4);
    #1;
    do_reset(2);
    add_frame(1'b1, 9, 31'd8);
    plan();
    wait_drain(200);
    check("post_reset_words", 80'(n_out), 80'(9));
    check("post_reset_data_cnt", 80'(DATA_FRAME_CNT), 80'(1));
    check("post_reset_stat_cnt", 80'(STAT_FRAME_CNT), 80'(0));

    // Counter wrap with single-word status frames
    do_reset(2);
    for (int i = 0; i < 17; i++) add_frame(1'b0, 1, 31'(200 + i));
    plan();
    wait_drain(300);
    check("wrap_stat_cnt", 80'(STAT_FRAME_CNT), 80'(1));

    // Randomized mixes with random back-pressure and intra-frame gaps
    for (int r = 0; r < 6; r++) begin
      do_reset(2);
      trdy_mode = 2; gap_max = 2;
      nd = $urandom_range(4, 0);
      ns = $urandom_range(8, 0);
      for (int i = 0; i < nd; i++) add_frame(1'b1, 9, 31'($urandom));
      for (int i = 0; i < ns; i++) add_frame(1'b0, $urandom_range(3, 1), 31'($urandom));
      plan();
      wait_drain(3000);
      check("rand_data_cnt", 80'(DATA_FRAME_CNT), 80'(nd % 16));
      check("rand_stat_cnt", 80'(STAT_FRAME_CNT), 80'(ns % 16));
      check("rand_busy", 80'(BUSY), 80'(0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/aurora_tx_arbiter.md
Name: aurora_tx_arbiter

Overview:
- Frame-atomic 2:1 arbiter that shares the single Aurora 64-bit TX stream between two sources:
  - the ADC/SDM data stream: 9-word frames out of the FWFT data FIFO;
  - the slow-control status/reply stream.
- Sits in the USER_CLK domain between the FIFO read ports and the Aurora core S_AXI_TX interface.
- Status frames get priority, but a burst limit prevents them from starving data.
- Registered output stage; per-source frame counters for monitoring.

Parameters:
- STAT_BURST_MAX, 4, max consecutive status frames granted while a data frame is waiting (1..15).
- CNT_W, 16, width of the frame counters.

Ports:
- CLK  in  1  USER_CLK domain clock.
- RESET_N  in  1  asynchronous, active-low reset.
- ENABLE  in  1  1 = new grants allowed; 0 = finish current frame, then hold IDLE.
- DATA_TDATA  in  64  data source word.
- DATA_TLAST  in  1  last word of data frame.
- DATA_TVALID  in  1  data word valid.
- DATA_TREADY  out  1  data word accepted.
- STAT_TDATA  in  64  status source word.
- STAT_TLAST  in  1  last word of status frame.
- STAT_TVALID  in  1  status word valid.
- STAT_TREADY  out  1  status word accepted.
- S_AXI_TX_TDATA  out  64  word to Aurora.
- S_AXI_TX_TLAST  out  1  frame end to Aurora.
- S_AXI_TX_TVALID  out  1  output word valid.
- S_AXI_TX_TREADY  in  1  Aurora accepts.
- BUSY  out  1  state != IDLE or output register occupied.
- DATA_FRAME_CNT  out  CNT_W  completed data frames, wraps.
- STAT_FRAME_CNT  out  CNT_W  completed status frames, wraps.

Behaviour:
- Reset (RESET_N=0, async): state=IDLE; output register empty; run counter=0; both frame counters=0.
  - All outputs 0.
  - A partial frame in flight is abandoned; the downstream sees TVALID=0 immediately.
- Handshake rules:
  - Transfer on any port = VALID & READY in the same cycle.
  - Sources must hold data while VALID & !READY.
- Output register:
  - load_ok = !S_AXI_TX_TVALID | S_AXI_TX_TREADY.
  - Granted source READY = load_ok & (state == its grant state).
  - Non-granted READY = 0.
  - On a source transfer, the output register loads {TDATA, TLAST} and sets TVALID=1.
  - Otherwise TVALID clears when TREADY=1.
  - Full throughput: 1 word/cycle when TREADY is held high.
  - Latency: source transfer to S_AXI_TX_TVALID is 1 cycle.
- State machine IDLE / DATA / STAT:
  - IDLE (no READY asserted):
    - If ENABLE=0 or no VALID: stay.
    - If STAT_TVALID and (!DATA_TVALID or run < STAT_BURST_MAX): go to STAT.
    - Else if DATA_TVALID: go to DATA.
    - Decision takes 1 cycle: 1 bubble cycle between frames.
  - STAT: on transfer with STAT_TLAST=1:
    - go to IDLE;
    - STAT_FRAME_CNT += 1;
    - run += 1, saturating at 15.
  - DATA: on transfer with DATA_TLAST=1:
    - go to IDLE;
    - DATA_FRAME_CNT += 1;
    - run = 0.
  - Run counter is also cleared to 0 when granting DATA.
  - Run counter does not change in IDLE when only status is pending with no data waiting; the burst limit applies only while DATA_TVALID=1.
- Frame atomicity:
  - The grant never changes mid-frame, regardless of ENABLE or the other source's VALID.
  - Deasserting ENABLE mid-frame takes effect at the next IDLE.
- Simultaneous events:
  - Last-word transfer and a new VALID on the other source in the same cycle: arbitrate in the following IDLE cycle.
  - Both sources valid at IDLE with run = STAT_BURST_MAX: DATA wins.
- Counters wrap from 2^CNT_W-1 to 0 with no flag.
- Single-word frames (VALID with TLAST on the first word) are legal.
- Back-pressure: TREADY=0 holds the output register.
  - The granted source sees READY=0 until the register drains.
  - No word is lost or duplicated.

Test Plan:
- Reset and single frame:
  - Reset low 3 cycles, release; TREADY=1; data-only 9-word frame (words 0..8, TLAST on word 8).
  - Required: 9 output words in order, TVALID continuous for 9 cycles, TLAST on the 9th word, DATA_FRAME_CNT=1.
- Priority with starvation limit:
  - STAT (2-word frames) and DATA both continuously valid, STAT_BURST_MAX=4.
  - Required grant order: S,S,S,S,D,S,S,S,S,D.
  - After 10 frames: STAT_FRAME_CNT=8, DATA_FRAME_CNT=2.
- Back-pressure:
  - During a data frame, TREADY toggles 1,0,0,1 repeatedly.
  - Required: output sequence identical to the input words 0..8; no READY to DATA while the register is held full.
- Frame atomicity:
  - STAT_TVALID rises at data word 3 and ENABLE drops at data word 5.
  - Required: data frame completes through word 8, then state stays IDLE, STAT_TREADY=0, BUSY=0 after the register drains.
  - Raising ENABLE again sends the status frame.
- Asynchronous reset mid-frame:
  - RESET_N low mid-frame at data word 4.
  - Required: TVALID=0 and both READYs=0 in the same cycle; counters=0.
  - After release, the next complete frame is forwarded normally.
- Counter wrap:
  - CNT_W=4, 17 single-word status frames.
  - Required: STAT_FRAME_CNT reads 1 (wrapped past 15).
